// File: rtl/paged_data_mem_pkg.sv
// Shared types, default sizes and geometry helpers for the paged data memory.
package paged_data_mem_pkg;

    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_ADDR_W    = 16;
    localparam int unsigned DEF_PAGE_BITS = 4;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    // Number of banks addressed by the page-select field.
    function automatic int unsigned num_pages(input int unsigned page_bits);
        return 32'd1 << page_bits;
    endfunction

    // Words per bank: whatever address bits remain below the page field.
    function automatic int unsigned page_depth(input int unsigned addr_w,
                                               input int unsigned page_bits);
        return 32'd1 << (addr_w - page_bits);
    endfunction

endpackage

// File: rtl/paged_data_mem_if.sv
// Request/response bus between the load/store stage and the paged data memory.
interface paged_data_mem_if
    import paged_data_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W/8-1:0]   req_be;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_data;
    logic                  rsp_err;

    // Load/store stage side.
    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    // Memory side.
    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/paged_data_mem_mem_bank.sv
// One page of storage: synchronous-read single-port RAM with byte write enables.
module mem_bank #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12,
    localparam int unsigned BE_W  = DATA_W / 8,
    localparam int unsigned DEPTH = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write and registered read; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/paged_data_mem.sv
// Banked data memory: request handshake, page decode, page-clear engine and read mux.
module paged_data_mem
    import paged_data_mem_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned PAGE_BITS  = DEF_PAGE_BITS,
    localparam int unsigned NUM_PAGES  = num_pages(PAGE_BITS),
    localparam int unsigned PAGE_DEPTH = page_depth(ADDR_W, PAGE_BITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    paged_data_mem_if.slave      bus,
    input  logic [NUM_PAGES-1:0] wp,
    input  logic                 clr_start,
    input  logic [PAGE_BITS-1:0] clr_page,
    output logic                 clr_busy,
    output logic                 clr_done
);

    localparam int unsigned OFF_W = ADDR_W - PAGE_BITS;
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(PAGE_DEPTH - 1);

    state_e                state_q, state_d;
    logic [OFF_W-1:0]      cnt_q, cnt_d;
    logic [PAGE_BITS-1:0]  clr_page_q, clr_page_d;
    logic                  done_q, done_d;

    logic [PAGE_BITS-1:0]  req_page;
    logic [OFF_W-1:0]      req_off;
    logic                  accept;
    logic                  do_write;
    logic                  do_read;
    logic                  clearing;

    logic [PAGE_BITS-1:0]  sel_page;
    logic [NUM_PAGES-1:0]  page_oh;
    logic [NUM_PAGES-1:0]  bank_we;
    logic [NUM_PAGES-1:0]  bank_re;
    logic [OFF_W-1:0]      bank_addr;
    logic [BE_W-1:0]       bank_be;
    logic [DATA_W-1:0]     bank_wdata;
    logic [DATA_W-1:0]     bank_rdata [NUM_PAGES];

    logic                  rsp_valid_q;
    logic                  rsp_rd_q;
    logic                  rsp_err_q;
    logic [PAGE_BITS-1:0]  rd_page_q;

    assign req_page = bus.req_addr[ADDR_W-1 -: PAGE_BITS];
    assign req_off  = bus.req_addr[OFF_W-1:0];

    // A clear request in the same cycle steals the port; the requester retries.
    assign bus.req_ready = (state_q == StIdle) && !clr_start && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign do_write      = accept && bus.req_we && !wp[req_page];
    assign do_read       = accept && !bus.req_we;
    // Gating with rst aborts the sweep on the very edge reset is sampled.
    assign clearing      = (state_q == StClear) && !rst;

    // Clear-engine next state: latch the page on start, sweep every offset once.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_page_d = clr_page_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d    = StClear;
                    cnt_d      = '0;
                    clr_page_d = clr_page;
                end
            end
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_OFF) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Clear-engine state, counter and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            clr_page_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_page_q <= clr_page_d;
            done_q     <= done_d;
        end
    end

    // Bank decode: the clear engine owns the banks while it runs.
    always_comb begin
        sel_page          = clearing ? clr_page_q : req_page;
        page_oh           = '0;
        page_oh[sel_page] = 1'b1;
        bank_addr         = clearing ? cnt_q : req_off;
        bank_be           = clearing ? {BE_W{1'b1}} : bus.req_be;
        bank_wdata        = clearing ? '0 : bus.req_wdata;
        bank_we           = (clearing || do_write) ? page_oh : '0;
        bank_re           = do_read ? page_oh : '0;
    end

    for (genvar p = 0; p < NUM_PAGES; p++) begin : g_bank
        mem_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (OFF_W)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[p]),
            .re    (bank_re[p]),
            .addr  (bank_addr),
            .be    (bank_be),
            .wdata (bank_wdata),
            .rdata (bank_rdata[p])
        );
    end

    // Response tracking: one registered pulse per accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rd_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_page_q   <= '0;
        end else begin
            rsp_valid_q <= accept;
            rsp_rd_q    <= do_read;
            rsp_err_q   <= accept && bus.req_we && wp[req_page];
            rd_page_q   <= req_page;
        end
    end

    // Outputs are forced low while reset is held; response fields are zero when idle.
    always_comb begin
        bus.rsp_valid = rsp_valid_q && !rst;
        bus.rsp_err   = rsp_err_q && !rst;
        bus.rsp_data  = (rsp_rd_q && !rst) ? bank_rdata[rd_page_q] : '0;
        clr_busy      = (state_q == StClear) && !rst;
        clr_done      = done_q && !rst;
    end

endmodule

// File: tb/tb_paged_data_mem.sv
// Self-checking bench: behavioural memory model compared every cycle, plus directed literal checks.
module tb_paged_data_mem;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 16;
    localparam int unsigned PB    = 4;
    localparam int unsigned NP    = 16;
    localparam int unsigned DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] wp = '0;
    logic          clr_start = 1'b0;
    logic [PB-1:0] clr_page = '0;
    logic          clr_busy;
    logic          clr_done;

    int checks   = 0;
    int failures = 0;

    paged_data_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    paged_data_mem #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .PAGE_BITS (PB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .wp        (wp),
        .clr_start (clr_start),
        .clr_page  (clr_page),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] model [int];
    bit            m_busy = 0;
    int            m_page = 0;
    int            m_idx  = 0;
    bit            e_valid = 0, e_err = 0, e_done = 0, e_known = 1;
    logic [DW-1:0] e_data = '0;

    always @(posedge clk) begin
        e_valid = 0; e_err = 0; e_done = 0; e_data = '0; e_known = 1;
        if (rst) begin
            m_busy = 0;
        end else if (m_busy) begin
            model[m_page * DEPTH + m_idx] = '0;
            m_idx++;
            if (m_idx == DEPTH) begin
                m_busy = 0;
                e_done = 1;
            end
        end else if (clr_start) begin
            m_busy = 1;
            m_page = int'(clr_page);
            m_idx  = 0;
        end else if (bus.req_valid) begin
            int a;
            a = int'(bus.req_addr);
            e_valid = 1;
            if (bus.req_we) begin
                if (wp[a / DEPTH]) begin
                    e_err = 1;
                end else if (model.exists(a)) begin
                    logic [DW-1:0] w;
                    w = model[a];
                    if (bus.req_be[0]) w[7:0]  = bus.req_wdata[7:0];
                    if (bus.req_be[1]) w[15:8] = bus.req_wdata[15:8];
                    model[a] = w;
                end else if (bus.req_be == 2'b11) begin
                    model[a] = bus.req_wdata;
                end
            end else if (model.exists(a)) begin
                e_data = model[a];
            end else begin
                e_known = 0;
            end
        end
    end

    // Compare process: every cycle, mid-period.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", 32'(bus.req_ready), 0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
            chk("rst_rsp_err", 32'(bus.rsp_err), 0);
            chk("rst_rsp_data", 32'(bus.rsp_data), 0);
            chk("rst_busy", 32'(clr_busy), 0);
            chk("rst_done", 32'(clr_done), 0);
        end else begin
            chk("ready", 32'(bus.req_ready), 32'(!m_busy && !clr_start));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_valid));
            chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
            if (e_known) chk("rsp_data", 32'(bus.rsp_data), 32'(e_data));
            chk("clr_busy", 32'(clr_busy), 32'(m_busy));
            chk("clr_done", 32'(clr_done), 32'(e_done));
        end
    end

    // ---------------- directed helpers ----------------
    // Called at posedge+1; drives one request for one cycle, returns at the next posedge+1
    // when that request's response is visible.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [1:0] be,
                         input logic [DW-1:0] wd);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_be    = be;
        bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic read_chk(input string name, input logic [AW-1:0] addr,
                            input logic [DW-1:0] exp);
        issue(1'b0, addr, 2'b00, '0);
        chk({name, "_valid"}, 32'(bus.rsp_valid), 1);
        chk({name, "_data"}, 32'(bus.rsp_data), 32'(exp));
        chk({name, "_err"}, 32'(bus.rsp_err), 0);
    endtask

    // Starts a clear and counts busy cycles and done pulses over a fixed window.
    task automatic run_clear(input logic [PB-1:0] page, input bit with_req,
                             input bit second_start, output int busy_n, output int done_n);
        clr_start = 1'b1;
        clr_page  = page;
        if (with_req) begin
            bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'hA000;
            bus.req_be = 2'b11; bus.req_wdata = 16'h1234;
            #1;
            chk("prio_ready", 32'(bus.req_ready), 0);
        end
        @(posedge clk); #1;
        clr_start = 1'b0;
        bus.req_valid = 1'b0;
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < DEPTH + 100; i++) begin
            if (clr_busy) busy_n++;
            if (clr_done) done_n++;
            if (second_start && i == 10) begin
                clr_start = 1'b1;
                clr_page  = 4'd3;
            end else begin
                clr_start = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int busy_n, done_n;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_be    = '0;
        bus.req_wdata = '0;
        idle(3);
        chk("rst_lit_ready", 32'(bus.req_ready), 0);
        chk("rst_lit_busy", 32'(clr_busy), 0);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        idle(1);

        // Basic write/read.
        issue(1'b1, 16'h1234, 2'b11, 16'hBEEF);
        chk("wr_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("wr_rsp_data", 32'(bus.rsp_data), 0);
        read_chk("rd1234", 16'h1234, 16'hBEEF);
        idle(1);
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 0);

        // Byte enables and back-to-back read-after-write.
        issue(1'b1, 16'h2000, 2'b11, 16'hAAAA);
        issue(1'b1, 16'h2000, 2'b10, 16'h5500);
        read_chk("rd2000", 16'h2000, 16'h55AA);
        issue(1'b1, 16'h2000, 2'b00, 16'h0000);
        chk("be0_rsp_valid", 32'(bus.rsp_valid), 1);
        read_chk("rd2000_be0", 16'h2000, 16'h55AA);

        // Write protection.
        issue(1'b1, 16'h3005, 2'b11, 16'hCAFE);
        wp = 16'h0008;
        issue(1'b1, 16'h3005, 2'b11, 16'h1111);
        chk("wp_err", 32'(bus.rsp_err), 1);
        chk("wp_valid", 32'(bus.rsp_valid), 1);
        wp = '0;
        read_chk("rd3005", 16'h3005, 16'hCAFE);

        // Page clear.
        issue(1'b1, 16'h7000, 2'b11, 16'hFFFF);
        issue(1'b1, 16'h7FFF, 2'b11, 16'hFFFF);
        issue(1'b1, 16'h8000, 2'b11, 16'hFFFF);
        idle(1);
        run_clear(4'd7, 1'b0, 1'b0, busy_n, done_n);
        chk("clr7_busy_cycles", 32'(busy_n), DEPTH);
        chk("clr7_done_pulses", 32'(done_n), 1);
        read_chk("rd7000", 16'h7000, 16'h0000);
        read_chk("rd7FFF", 16'h7FFF, 16'h0000);
        read_chk("rd8000", 16'h8000, 16'hFFFF);

        // Clear beats a same-cycle request; a start during clear is ignored.
        issue(1'b1, 16'hA000, 2'b11, 16'h0F0F);
        idle(1);
        run_clear(4'd9, 1'b1, 1'b1, busy_n, done_n);
        chk("clr9_busy_cycles", 32'(busy_n), DEPTH);
        chk("clr9_done_pulses", 32'(done_n), 1);
        read_chk("rdA000", 16'hA000, 16'h0F0F);
        read_chk("rd3005_after", 16'h3005, 16'hCAFE);

        // Reset in the middle of a clear.
        issue(1'b1, 16'h5000, 2'b11, 16'h1357);
        issue(1'b1, 16'h5FFF, 2'b11, 16'h2468);
        clr_start = 1'b1;
        clr_page  = 4'd5;
        idle(1);
        clr_start = 1'b0;
        idle(100);
        rst = 1'b1;
        idle(1);
        chk("rstmid_busy", 32'(clr_busy), 0);
        chk("rstmid_done", 32'(clr_done), 0);
        rst = 1'b0;
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (clr_done) done_n++;
            idle(1);
        end
        chk("rstmid_no_done", 32'(done_n), 0);
        read_chk("rd5000", 16'h5000, 16'h0000);
        read_chk("rd5FFF", 16'h5FFF, 16'h2468);

        // Randomized traffic against the model.
        for (int i = 0; i < 12000; i++) begin
            logic [15:0] offs [6];
            offs = '{16'h000, 16'h001, 16'h002, 16'h7FE, 16'hFFE, 16'hFFF};
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_we    = $urandom_range(0, 1) == 1;
            bus.req_addr  = {4'($urandom_range(0, 15)), offs[$urandom_range(0, 5)][11:0]};
            bus.req_be    = 2'($urandom);
            bus.req_wdata = 16'($urandom);
            wp            = 16'($urandom & $urandom & $urandom);
            clr_start     = ($urandom_range(0, 3999) == 0);
            clr_page      = 4'($urandom);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        clr_start     = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/paged_data_mem.md
Name: paged_data_mem

Overview:
Parametrised, banked, single-port data memory. Successor to the fixed 16-page/16-bit data memory.
- Address space is split into 2^PAGE_BITS pages, each a separate bank selected by the upper address bits.
- Adds a valid/ready request handshake, a registered 1-cycle read response, per-byte write enables and per-page write protection.
- Adds a hardware page-clear engine (FSM plus counter) that zero-fills one page.
- Sits between the processor load/store stage and the page banks.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8.
ADDR_W, 16, word-address width.
PAGE_BITS, 4, page-select bits taken from REQ_ADDR[ADDR_W-1 -: PAGE_BITS]; NUM_PAGES = 2^PAGE_BITS.
PAGE_DEPTH (derived, not overridable), 2^(ADDR_W-PAGE_BITS), words per page.

Ports:
CLK  in  1  single clock; all state updates on rising edge.
RST  in  1  synchronous, active-high reset.
REQ_VALID  in  1  request present.
REQ_READY  out  1  block accepts request this cycle.
REQ_WE  in  1  1 = write, 0 = read.
REQ_ADDR  in  ADDR_W  word address.
REQ_BE  in  DATA_W/8  byte enables (writes only).
REQ_WDATA  in  DATA_W  write data.
WP  in  NUM_PAGES  per-page write-protect; bit p = 1 blocks writes to page p.
CLR_START  in  1  pulse: start zero-fill of page CLR_PAGE.
CLR_PAGE  in  PAGE_BITS  page to clear; sampled with CLR_START.
CLR_BUSY  out  1  clear engine active.
CLR_DONE  out  1  one-cycle pulse after the last word of the page is cleared.
RSP_VALID  out  1  one-cycle response pulse.
RSP_DATA  out  DATA_W  read data; 0 for write responses.
RSP_ERR  out  1  valid with RSP_VALID; 1 = write was dropped because the page is protected.

Behaviour:
- Reset: synchronous, active-high, on CLK.
  - While RST = 1: state = IDLE; REQ_READY, CLR_BUSY, CLR_DONE, RSP_VALID and RSP_ERR = 0; RSP_DATA = 0; clear counter = 0.
  - Memory contents are not reset.
- States: IDLE, CLEAR.
- REQ_READY = (state == IDLE) && !CLR_START && !RST. This is combinational. A request is accepted when REQ_VALID && REQ_READY.
- Accepted read:
  - In cycle N+1: RSP_VALID = 1, RSP_DATA = mem[REQ_ADDR], RSP_ERR = 0.
  - Fixed latency 1; no back-pressure on responses.
  - Back-to-back reads give one response per cycle.
- Accepted write, target page not protected:
  - Bytes with REQ_BE[i] = 1 are written at the accepting edge; other bytes are unchanged.
  - In cycle N+1: RSP_VALID = 1, RSP_ERR = 0, RSP_DATA = 0.
  - REQ_BE = 0 is a legal no-op write and still gets a response.
- Accepted write, WP[page] = 1: memory is unchanged; in cycle N+1, RSP_VALID = 1 and RSP_ERR = 1.
- Read-after-write, same address, back-to-back: the read returns the newly written data.
- Response fields hold their values only while RSP_VALID = 1. When RSP_VALID = 0, RSP_DATA = 0 and RSP_ERR = 0.
- Clear:
  - CLR_START in IDLE: CLR_PAGE is latched, counter = 0, next state = CLEAR, and the request port is not ready in that same cycle. A pending request's response from the prior cycle still completes.
  - In CLEAR: each cycle writes 0 to {page, counter} and increments the counter. CLR_BUSY = 1.
  - After PAGE_DEPTH writes (counter wraps from PAGE_DEPTH-1): next state = IDLE, and CLR_DONE pulses for one cycle in the first IDLE cycle.
  - Clear ignores WP. A full clear takes PAGE_DEPTH cycles.
  - CLR_START while in CLEAR is ignored.
- Priority in IDLE: CLR_START wins over REQ_VALID; the request must be retried.
- Reset mid-clear: the engine aborts, no CLR_DONE is issued, and already-cleared words stay cleared.
- Page select is a one-hot decode of the upper PAGE_BITS. Only the selected bank sees a write enable. The read mux uses a registered page select.

Decomposition:
- Package paged_data_mem_pkg holds:
  - the state enum {IDLE, CLEAR};
  - default DATA_W / ADDR_W / PAGE_BITS constants;
  - a function computing NUM_PAGES and PAGE_DEPTH.
- One sub-module, mem_bank: a PAGE_DEPTH x DATA_W synchronous-read bank with byte enables, instantiated NUM_PAGES times in a generate loop.
- The top level holds the handshake, the decode, the clear FSM/counter and the output mux.

Test Plan (defaults: 16 pages x 4096 words x 16 bits):
- Reset, then write 0xBEEF to 0x1234 (BE = 11), then read 0x1234 → RSP_VALID one cycle after the read is accepted, RSP_DATA = 0xBEEF, RSP_ERR = 0; all outputs 0 while RST = 1.
- Write 0xAAAA to 0x2000, then write 0x5500 with BE = 10, then read 0x2000 → 0x55AA. The back-to-back read returns new data.
- WP[3] = 1, write 0x1111 to 0x3005 → RSP_ERR = 1. WP = 0, then read 0x3005 → the prior contents, unchanged.
- Fill 0x7000, 0x7FFF and 0x8000 with 0xFFFF; pulse CLR_START with CLR_PAGE = 7:
  - REQ_READY = 0 during the clear;
  - CLR_BUSY = 1 for 4096 cycles, then CLR_DONE pulses once;
  - reads at 0x7000 and 0x7FFF return 0, 0x8000 returns 0xFFFF.
- CLR_START and REQ_VALID in the same IDLE cycle → the request is not accepted, the clear runs; a second CLR_START during CLEAR is ignored (exactly one CLR_DONE).
- Assert RST 100 cycles into a page-5 clear → CLR_BUSY = 0 the next cycle, no CLR_DONE; 0x5000 reads 0, 0x5FFF retains its prior value.
